// File: rtl/safe_pkg.sv
// Shared types and default parameters for the safe access controller and the
// serial code checker bench.
package safe_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    WAIT    = 3'd2,
    OPEN    = 3'd3,
    LOCKOUT = 3'd4
  } safe_state_t;

  localparam int SAFE_N            = 4;
  localparam int SAFE_MAX_FAIL     = 3;
  localparam int SAFE_LOCK_CYCLES  = 64;
  localparam int SAFE_OPEN_CYCLES  = 16;
  localparam int SAFE_RESP_TIMEOUT = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/safe_timer.sv
// Loadable down-counter shared by the response-wait, door-open and lockout
// phases; it parks at zero until reloaded.
module safe_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/safe_ctrl.sv
// Safe access controller: accepts a keypad code, serialises it MSB-first to the
// checker, interprets the response, drives the door and enforces lockout.
module safe_ctrl
  import safe_pkg::*;
#(
  parameter int N            = SAFE_N,
  parameter int MAX_FAIL     = SAFE_MAX_FAIL,
  parameter int LOCK_CYCLES  = SAFE_LOCK_CYCLES,
  parameter int OPEN_CYCLES  = SAFE_OPEN_CYCLES,
  parameter int RESP_TIMEOUT = SAFE_RESP_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          code_valid,
  input  logic [N-1:0]                  code_in,
  output logic                          code_ready,
  output logic                          ser_valid,
  output logic                          ser_data,
  input  logic                          unlock_valid,
  input  logic                          unlock,
  input  logic                          incorrect,
  output logic                          door_open,
  output logic                          locked_out,
  output logic                          result_valid,
  output logic                          result_ok,
  output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

  localparam int TW = $clog2(max3(LOCK_CYCLES, OPEN_CYCLES, RESP_TIMEOUT) + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  // The timer signals expiry while it reads zero, so each phase loads its
  // length minus one to last exactly that many cycles.
  localparam logic [TW-1:0] RESP_LOAD = TW'(RESP_TIMEOUT - 1);
  localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);
  localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAIL);
  localparam logic [IW-1:0] IDX_TOP   = IW'(N - 1);

  safe_state_t   state_q, state_d;
  logic [N-1:0]  code_q, code_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          code_ready_q, code_ready_d;
  logic          ser_valid_q, ser_valid_d;
  logic          ser_data_q, ser_data_d;
  logic          door_open_q, door_open_d;
  logic          locked_out_q, locked_out_d;
  logic          result_valid_q, result_valid_d;
  logic          result_ok_q, result_ok_d;
  logic [FW-1:0] fail_cnt_q, fail_cnt_d;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;
  logic          incorrect_unused;

  // A fail is decided from unlock_valid/unlock alone.
  assign incorrect_unused = incorrect;

  safe_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rstn       (rstn),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d        = state_q;
    code_d         = code_q;
    idx_d          = idx_q;
    ser_valid_d    = 1'b0;
    ser_data_d     = 1'b0;
    door_open_d    = 1'b0;
    locked_out_d   = 1'b0;
    result_valid_d = 1'b0;
    result_ok_d    = 1'b0;
    fail_cnt_d     = fail_cnt_q;
    tmr_load       = 1'b0;
    tmr_val        = '0;

    case (state_q)
      IDLE: begin
        if (code_valid && code_ready_q) begin
          code_d      = code_in;
          idx_d       = IDX_TOP;
          ser_valid_d = 1'b1;
          ser_data_d  = code_in[N-1];
          state_d     = SHIFT;
        end
      end

      SHIFT: begin
        if (idx_q == '0) begin
          state_d  = WAIT;
          tmr_load = 1'b1;
          tmr_val  = RESP_LOAD;
        end else begin
          idx_d       = idx_q - 1'b1;
          ser_valid_d = 1'b1;
          ser_data_d  = code_q[idx_d];
        end
      end

      // A response takes priority over a timer expiry in the same cycle.
      WAIT: begin
        if (unlock_valid && unlock) begin
          result_valid_d = 1'b1;
          result_ok_d    = 1'b1;
          fail_cnt_d     = '0;
          door_open_d    = 1'b1;
          state_d        = OPEN;
          tmr_load       = 1'b1;
          tmr_val        = OPEN_LOAD;
        end else if (unlock_valid || tmr_zero) begin
          result_valid_d = 1'b1;
          if (fail_cnt_q != FAIL_MAX) begin
            fail_cnt_d = fail_cnt_q + 1'b1;
          end
          if (fail_cnt_d == FAIL_MAX) begin
            locked_out_d = 1'b1;
            state_d      = LOCKOUT;
            tmr_load     = 1'b1;
            tmr_val      = LOCK_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end

      OPEN: begin
        if (tmr_zero) begin
          state_d = IDLE;
        end else begin
          door_open_d = 1'b1;
        end
      end

      LOCKOUT: begin
        if (tmr_zero) begin
          fail_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          locked_out_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    code_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q        <= IDLE;
      code_q         <= '0;
      idx_q          <= '0;
      code_ready_q   <= 1'b0;
      ser_valid_q    <= 1'b0;
      ser_data_q     <= 1'b0;
      door_open_q    <= 1'b0;
      locked_out_q   <= 1'b0;
      result_valid_q <= 1'b0;
      result_ok_q    <= 1'b0;
      fail_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      code_q         <= code_d;
      idx_q          <= idx_d;
      code_ready_q   <= code_ready_d;
      ser_valid_q    <= ser_valid_d;
      ser_data_q     <= ser_data_d;
      door_open_q    <= door_open_d;
      locked_out_q   <= locked_out_d;
      result_valid_q <= result_valid_d;
      result_ok_q    <= result_ok_d;
      fail_cnt_q     <= fail_cnt_d;
    end
  end

  assign code_ready   = code_ready_q;
  assign ser_valid    = ser_valid_q;
  assign ser_data     = ser_data_q;
  assign door_open    = door_open_q;
  assign locked_out   = locked_out_q;
  assign result_valid = result_valid_q;
  assign result_ok    = result_ok_q;
  assign fail_cnt     = fail_cnt_q;

endmodule

// File: doc/safe_ctrl.md
# safe_ctrl

Access controller for the digital-safe serial code checker (`fsmml`). It accepts a parallel N-bit code from the keypad side through a valid/ready handshake and serialises it MSB-first onto the checker's `ser_valid`/`ser_data` inputs. It then interprets the checker's `unlock_valid`/`unlock`/`incorrect` response and drives the door-open pulse. It also counts consecutive failures and enforces a timed lockout after `MAX_FAIL` failures.

## Interface
Parameters:
- `N`, 4: code width in bits; must match the checker.
- `MAX_FAIL`, 3: consecutive failures that trigger lockout; ≥1.
- `LOCK_CYCLES`, 64: lockout duration in clock cycles; ≥1.
- `OPEN_CYCLES`, 16: `door_open` pulse length in cycles; ≥1.
- `RESP_TIMEOUT`, 8: maximum wait for a checker response after the last bit; ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: reset, synchronous, active-low.
- `code_valid` in 1: keypad code is valid.
- `code_in` in N: keypad code; bit N-1 is sent first.
- `code_ready` out 1: controller can accept a code.
- `ser_valid` out 1: serial bit is valid; goes to the checker.
- `ser_data` out 1: serial bit; goes to the checker.
- `unlock_valid` in 1: checker response strobe.
- `unlock` in 1: checker reports the code matched.
- `incorrect` in 1: checker reports a mismatch (informational; a fail is `unlock_valid && !unlock`).
- `door_open` out 1: door actuator enable.
- `locked_out` out 1: lockout is active.
- `result_valid` out 1: one-cycle attempt-complete strobe.
- `result_ok` out 1: outcome of the attempt; qualified by `result_valid`.
- `fail_cnt` out $clog2(MAX_FAIL+1): current consecutive-failure count.

## Operation
- States: `IDLE`, `SHIFT`, `WAIT`, `OPEN`, `LOCKOUT`.
- `IDLE`:
  - `code_ready`=1.
  - On `code_valid && code_ready`, latch `code_in` into the shift register, set the bit index to N-1, go to `SHIFT`.
- `SHIFT`:
  - `ser_valid`=1 and `ser_data`=`code[idx]` for exactly N consecutive cycles, in order N-1 down to 0.
  - After bit 0, go to `WAIT` and load the timer with `RESP_TIMEOUT`.
- `WAIT`: `ser_valid`=0.
  - `unlock_valid && unlock`: pass. Pulse `result_valid` with `result_ok`=1, clear `fail_cnt`, go to `OPEN` with the timer loaded to `OPEN_CYCLES`.
  - `unlock_valid && !unlock`: fail.
  - Timer reaches 0 with no response: fail.
  - On a fail: pulse `result_valid` with `result_ok`=0 and increment `fail_cnt`.
    - If the new count equals `MAX_FAIL`, go to `LOCKOUT` with the timer loaded to `LOCK_CYCLES`.
    - Otherwise go to `IDLE`.
- `OPEN`: `door_open`=1 for exactly `OPEN_CYCLES` cycles, then `IDLE`.
- `LOCKOUT`:
  - `locked_out`=1 for exactly `LOCK_CYCLES` cycles.
  - `fail_cnt` holds at `MAX_FAIL` during lockout.
  - On exit, clear `fail_cnt` and go to `IDLE`.
- `code_ready`=0 in every state except `IDLE`. Codes presented then are not consumed; the keypad holds `code_valid`.
- `unlock_valid` outside `WAIT` is ignored: no state change and no `result_valid`.
- A response and a timer expiry in the same `WAIT` cycle: the response wins.
- `fail_cnt` saturates and never wraps. The counter is cleared only by a pass, the end of lockout, or reset.

## Timing
- All outputs are registered.
- Reset values: `code_ready`=0, `ser_valid`=0, `ser_data`=0, `door_open`=0, `locked_out`=0, `result_valid`=0, `result_ok`=0, `fail_cnt`=0. State is `IDLE`; `code_ready` rises the cycle after `rstn` is released.
- Handshake accepted at edge E0:
  - `code_ready` drops after E0.
  - `ser_valid`=1 with bit N-1 during E0..E1; the checker samples bit N-1 at E1, bit 0 at EN.
  - `ser_valid`=0 after EN.
- Response sampled at edge Er: `result_valid` is high for the one cycle after Er; `door_open` or `locked_out` rises at Er.
- Timeout: if no `unlock_valid` is seen at edges EN+1..EN+RESP_TIMEOUT, the fail is taken at EN+RESP_TIMEOUT.
- Back-to-back attempts: the earliest next acceptance is the edge after `IDLE` is re-entered.
- `rstn`=0 at any edge, including mid-`SHIFT`, mid-`OPEN` or mid-`LOCKOUT`, forces reset values at that edge. A partially shifted code is abandoned with `ser_valid`=0 immediately.

## Structure
- Package `safe_pkg`:
  - `typedef enum logic [2:0]` `safe_state_t` for the five states.
  - Default constants `SAFE_N`, `SAFE_MAX_FAIL`, `SAFE_LOCK_CYCLES`, `SAFE_OPEN_CYCLES`, `SAFE_RESP_TIMEOUT`.
  - Shared with the `fsmml` bench and the top level.
- Sub-module `safe_timer`:
  - Loadable down-counter with `load`, `load_val`, `zero` outputs.
  - Width $clog2(max(LOCK_CYCLES, OPEN_CYCLES, RESP_TIMEOUT)+1).
  - One instance, shared by `WAIT`, `OPEN` and `LOCKOUT`.
- Top bench instantiates `safe_ctrl` and `fsmml` connected with `.*` (stored code 4'b1011).

## Test plan
- Reset, then `code_in`=4'b1011 → `ser_data` sequence 1,0,1,1 on 4 consecutive `ser_valid` cycles → `result_valid`/`result_ok`=1, `door_open` high exactly 16 cycles, `fail_cnt`=0.
- `code_in`=4'b1100 → `result_ok`=0 and `fail_cnt`=1. Then 4'b1011 → pass and `fail_cnt`=0.
- Codes 4'b1100, 4'b1101, 4'b0101 → `fail_cnt` 1, 2, 3. `locked_out`=1 for exactly 64 cycles, with `code_ready`=0 throughout even while `code_valid`=1. Then `fail_cnt`=0 and `code_ready`=1.
- Checker response stubbed off → fail declared exactly 8 cycles after the last bit: `result_ok`=0, `fail_cnt`+1.
- `rstn`=0 after 2 bits of 4'b1011 → `ser_valid`=0 at that edge, all outputs at reset values, and no `result_valid` is ever produced for the aborted code.
- Spurious `unlock_valid`=1 in `IDLE` and in `OPEN` → no state change and no `result_valid`.
